// File: rtl/counter_pkg.sv
// Shared encodings for the counter library: FSM states and timer modes.
package counter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/down_count_reg.sv
// WIDTH-bit count register: sync reset, load, decrement or hold, with a zero flag.
module down_count_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_en_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             dec_en_i,
  output logic [WIDTH-1:0] q_o,
  output logic             zero_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_en_i)       cnt_d = ld_val_i;
    else if (dec_en_i) cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q_o    = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter / timer: one-shot stops at zero, periodic reloads
// (divide-by-(reload+1)). tc/busy/done are decodes of registered state.
module sync_down_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RELOAD_INIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             cnt_ld, cnt_dec, cnt_zero;
  logic [WIDTH-1:0] cnt_ld_val;

  down_count_reg #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .ld_en_i  (cnt_ld),
    .ld_val_i (cnt_ld_val),
    .dec_en_i (cnt_dec),
    .q_o      (q),
    .zero_o   (cnt_zero)
  );

  // Priority: load > stop > start > count (reset handled in the registers).
  always_comb begin
    state_d    = state_q;
    reload_d   = reload_q;
    mode_d     = mode_q;
    cnt_ld     = 1'b0;
    cnt_ld_val = reload_q;
    cnt_dec    = 1'b0;
    if (load) begin
      reload_d   = load_val;
      cnt_ld     = 1'b1;
      cnt_ld_val = load_val;
      state_d    = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_IDLE;
      if (state_q == ST_DONE) begin
        state_d    = ST_IDLE;
        cnt_ld     = 1'b1;
        cnt_ld_val = '0;
      end
    end else if (start && state_q != ST_RUN) begin
      state_d = ST_RUN;
      mode_d  = mode;
      // Restart from DONE reloads; resume from IDLE keeps the paused count.
      if (state_q == ST_DONE) cnt_ld = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (!cnt_zero)                    cnt_dec = 1'b1;
      else if (mode_q == MODE_PERIODIC) cnt_ld  = 1'b1;
      else                              state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reload_q <= RELOAD_INIT;
      mode_q   <= MODE_ONESHOT;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign tc   = busy && cnt_zero;
endmodule

// File: tb/tb_sync_down_counter.sv
// Table-driven bench for sync_down_counter with a queue scoreboard of expected outputs.
module tb_sync_down_counter;
  logic       clk = 1'b0;
  logic       reset, load, start, stop, mode;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, busy, done;

  int checks = 0;
  int failures = 0;

  sync_down_counter #(.WIDTH(4), .RELOAD_INIT(4'hF)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .mode(mode),
    .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, l;
    logic [3:0] lv;
    logic       s, p, m;
    logic [3:0] eq;
    logic       etc, ebusy, edone;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       tc, busy, done;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic l, logic [3:0] lv, logic s, logic p, logic m,
                              logic [3:0] eq, logic etc, logic eb, logic ed);
    vec_t v;
    v.r = r; v.l = l; v.lv = lv; v.s = s; v.p = p; v.m = m;
    v.eq = eq; v.etc = etc; v.ebusy = eb; v.edone = ed;
    return v;
  endfunction

  // Inputs are set at negedge, expectation queued, outputs checked #1 after posedge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e, got;
    @(negedge clk);
    reset = v.r; load = v.l; load_val = v.lv; start = v.s; stop = v.p; mode = v.m;
    e.q = v.eq; e.tc = v.etc; e.busy = v.ebusy; e.done = v.edone; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (q !== got.q || tc !== got.tc || busy !== got.busy || done !== got.done) begin
      failures++;
      $display("FAIL vec%0d q/tc/busy/done got %h/%b/%b/%b want %h/%b/%b/%b",
               got.idx, q, tc, busy, done, got.q, got.tc, got.busy, got.done);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    reset = 0; load = 0; start = 0; stop = 0; mode = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tc_cnt;
    int busy_low;
    reset = 1; load = 0; load_val = 0; start = 0; stop = 0; mode = 0;

    //                r  l  lv    s  p  m   q     tc b  d
    // reset, then start with no load: immediate tc then done
    vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1));
    // one-shot from 5, then restart from DONE
    vecs.push_back(mk(0, 1, 4'h5, 0, 0, 0, 4'h5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h4, 0, 1, 0));
    // periodic from 3
    vecs.push_back(mk(0, 1, 4'h3, 0, 0, 0, 4'h3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h3, 0, 1, 0));
    // periodic reload 0: tc held high
    vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0));
    // pause / resume, stop beats start
    vecs.push_back(mk(0, 1, 4'h9, 0, 0, 0, 4'h9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h9, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h8, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h7, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h6, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h6, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 0, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h4, 0, 0, 0));
    // load beats start mid-run
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h2, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'hA, 1, 0, 0, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'hA, 0, 0, 0));
    // load in DONE clears done
    vecs.push_back(mk(0, 1, 4'h1, 0, 0, 0, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'h2, 0, 0, 0, 4'h2, 0, 0, 0));
    // start in RUN ignored (mode stays one-shot), stop in DONE
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));
    // reset mid periodic run restores reload=F
    vecs.push_back(mk(0, 1, 4'h9, 0, 0, 0, 4'h9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h9, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h8, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h7, 0, 1, 0));
    vecs.push_back(mk(1, 1, 4'h3, 1, 0, 1, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'hF, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 4'hE, 0, 1, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Periodic divide-by-3: over 12 cycles after start expect exactly 4 tc pulses.
    apply(mk(0, 1, 4'h2, 0, 0, 0, 4'h2, 0, 0, 0), 1000);
    apply(mk(0, 0, 4'h0, 1, 0, 1, 4'h2, 0, 1, 0), 1001);
    tc_cnt = 0;
    busy_low = 0;
    for (int k = 0; k < 12; k++) begin
      idle_cycle();
      if (tc === 1'b1) tc_cnt++;
      if (busy !== 1'b1) busy_low++;
    end
    checks++;
    if (tc_cnt != 4) begin
      failures++;
      $display("FAIL period_tc_count got %0d want 4", tc_cnt);
    end
    checks++;
    if (busy_low != 0) begin
      failures++;
      $display("FAIL period_busy_drop got %0d low cycles want 0", busy_low);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
